vdp_port_ctrl: RTL and testbench

Parametrised VDP CPU-port controller that sits between the port decoder strobes (CSW_L/CSR_L/MODE equivalents) and the VDP memory/register back end. It implements the SMS-style two-byte control-port command latch, the address register with auto-increment, and the read-ahead buffer. It also provides a posted access queue of configurable depth with a req/ack handshake toward VRAM/CRAM arbitration, and one-cycle register-write pulses for the register file.

---
 rtl/vdp_port_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_vdp_port_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_port_ctrl.sv
// vdp_port_ctrl -- VDP CPU-port controller.
//
// Sits between the CPU port decoder strobes and the VDP memory/register back
// end. It holds the two-byte control-port command latch, the auto-incrementing
// address register, the read-ahead buffer and a posted access FIFO that
// presents its head to the VRAM/CRAM arbiter through a req/ack handshake.
//
// Optional build macro: VDP_WRBUF_LOAD_EN
//   defined   : a data-port write also loads rd_buf with the written byte
//   undefined : data-port writes leave rd_buf untouched
//
// Ports:
//   clk, reset_L          clock, asynchronous active-low reset
//   cs_wr, cs_rd          one-cycle write / read strobes (write wins if both)
//   sel_ctrl              1 = control port, 0 = data port
//   wdata                 CPU write byte
//   rdata                 CPU read byte (status_in on control, rd_buf on data)
//   status_in             status byte from the timing logic
//   status_rd             one-cycle pulse after a control-port read
//   reg_we/reg_idx/reg_data  one-cycle register-file write
//   mem_req/mem_we/mem_tgt/mem_addr/mem_wdata  FIFO head toward the arbiter
//   mem_ack, mem_rdata    head accepted this cycle; read data in that cycle
//   q_full                FIFO full
//   ovf                   sticky: a data access was dropped on a full FIFO
module vdp_port_ctrl #(
  parameter int ADDR_W    = 14,
  parameter int CRAM_AW   = 5,
  parameter int REG_IDX_W = 4,
  parameter int Q_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 cs_wr,
  input  logic                 cs_rd,
  input  logic                 sel_ctrl,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  input  logic [7:0]           status_in,
  output logic                 status_rd,
  output logic                 reg_we,
  output logic [REG_IDX_W-1:0] reg_idx,
  output logic [7:0]           reg_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_tgt,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 q_full,
  output logic                 ovf
);

  localparam int PW = $clog2(Q_DEPTH);
  localparam int EW = ADDR_W + 10;  // {we, tgt, addr, data}
  localparam logic [PW:0]       CNT_FULL  = (PW+1)'(Q_DEPTH);
  localparam logic [ADDR_W-1:0] CRAM_MASK = ADDR_W'((1 << CRAM_AW) - 1);

  logic [ADDR_W-1:0]    addr_reg;
  logic [1:0]           code_reg;
  logic                 first_done_reg;
  logic [7:0]           rd_buf_reg;
  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]          count_reg;
  logic                 reg_we_reg;
  logic [REG_IDX_W-1:0] reg_idx_reg;
  logic [7:0]           reg_data_reg;
  logic                 status_rd_reg;
  logic                 ovf_reg;

  logic [EW-1:0] q_mem [Q_DEPTH];
  logic [EW-1:0] head_entry;

  logic              wr_ev, rd_ev, ctrl_hi;
  logic [ADDR_W-1:0] new_addr, enq_addr;
  logic              enq_req, enq_we, enq_tgt, enq_ok;
  logic [7:0]        enq_data;
  logic              pop, full;

  always_comb begin
    wr_ev    = cs_wr;
    rd_ev    = cs_rd & ~cs_wr;
    ctrl_hi  = wr_ev & sel_ctrl & first_done_reg;
    new_addr = addr_reg;
    if (ctrl_hi) new_addr[ADDR_W-1:8] = wdata[ADDR_W-9:0];
    enq_req  = 1'b0;
    enq_we   = 1'b0;
    enq_tgt  = 1'b0;
    enq_data = 8'h00;
    if (ctrl_hi && wdata[7:6] == 2'b00) enq_req = 1'b1;
    if (wr_ev && !sel_ctrl) begin
      enq_req  = 1'b1;
      enq_we   = 1'b1;
      enq_tgt  = (code_reg == 2'b11);
      enq_data = wdata;
    end
    if (rd_ev && !sel_ctrl) enq_req = 1'b1;
    // CRAM entries carry only the CRAM-sized part of the address.
    enq_addr = enq_tgt ? (new_addr & CRAM_MASK) : new_addr;
    pop      = mem_ack & (count_reg != '0);
    full     = (count_reg == CNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    enq_ok   = enq_req & (~full | pop);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      addr_reg       <= '0;
      code_reg       <= 2'b00;
      first_done_reg <= 1'b0;
      rd_buf_reg     <= 8'h00;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      reg_we_reg     <= 1'b0;
      reg_idx_reg    <= '0;
      reg_data_reg   <= 8'h00;
      status_rd_reg  <= 1'b0;
      ovf_reg        <= 1'b0;
    end else begin
      reg_we_reg    <= 1'b0;
      status_rd_reg <= 1'b0;
      if (pop && !head_entry[EW-1]) rd_buf_reg <= mem_rdata;
`ifdef VDP_WRBUF_LOAD_EN
      if (wr_ev && !sel_ctrl) rd_buf_reg <= wdata;
`endif
      if (enq_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)    rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (enq_ok && !pop)      count_reg <= count_reg + 1'b1;
      else if (!enq_ok && pop) count_reg <= count_reg - 1'b1;

      if (wr_ev) begin
        if (sel_ctrl) begin
          if (!first_done_reg) begin
            addr_reg[7:0]  <= wdata;
            first_done_reg <= 1'b1;
          end else begin
            first_done_reg <= 1'b0;
            code_reg       <= wdata[7:6];
            // enq_ok can only be set here by a code-00 prefetch.
            addr_reg       <= enq_ok ? new_addr + 1'b1 : new_addr;
            if (wdata[7:6] == 2'b10) begin
              reg_we_reg   <= 1'b1;
              reg_idx_reg  <= wdata[REG_IDX_W-1:0];
              reg_data_reg <= addr_reg[7:0];
            end
          end
        end else begin
          first_done_reg <= 1'b0;
          if (enq_ok) addr_reg <= new_addr + 1'b1;
          else        ovf_reg  <= 1'b1;
        end
      end else if (rd_ev) begin
        first_done_reg <= 1'b0;
        if (sel_ctrl) begin
          status_rd_reg <= 1'b1;
          ovf_reg       <= 1'b0;
        end else if (enq_ok) begin
          addr_reg <= new_addr + 1'b1;
        end else begin
          ovf_reg <= 1'b1;
        end
      end
    end
  end

  // FIFO storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq_ok) q_mem[wr_ptr_reg] <= {enq_we, enq_tgt, enq_addr, enq_data};
  end

  assign head_entry = q_mem[rd_ptr_reg];
  assign mem_req    = (count_reg != '0);
  assign mem_we     = head_entry[EW-1];
  assign mem_tgt    = head_entry[EW-2];
  assign mem_addr   = head_entry[EW-3:8];
  assign mem_wdata  = head_entry[7:0];
  assign q_full     = full;
  assign ovf        = ovf_reg;
  assign reg_we     = reg_we_reg;
  assign reg_idx    = reg_idx_reg;
  assign reg_data   = reg_data_reg;
  assign status_rd  = status_rd_reg;
  assign rdata      = sel_ctrl ? status_in : rd_buf_reg;

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Testbench for vdp_port_ctrl: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the port behaviour.
module tb_vdp_port_ctrl;
  localparam int AW    = 14;
  localparam int QD    = 4;
  localparam int ASIZE = 1 << AW;

  logic       clk, reset_L;
  logic       cs_wr, cs_rd, sel_ctrl;
  logic [7:0] wdata, rdata, status_in;
  logic       status_rd, reg_we;
  logic [3:0] reg_idx;
  logic [7:0] reg_data;
  logic       mem_req, mem_we, mem_tgt;
  logic [AW-1:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       q_full, ovf;

  vdp_port_ctrl dut (
    .clk(clk), .reset_L(reset_L), .cs_wr(cs_wr), .cs_rd(cs_rd),
    .sel_ctrl(sel_ctrl), .wdata(wdata), .rdata(rdata), .status_in(status_in),
    .status_rd(status_rd), .reg_we(reg_we), .reg_idx(reg_idx),
    .reg_data(reg_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_tgt(mem_tgt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .q_full(q_full), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  typedef struct { bit we; bit tgt; int addr; int data; } entry_t;
  entry_t mq[$];
  int  m_addr, m_code, m_rdbuf, m_reg_idx, m_reg_data;
  bit  m_fd, m_ovf, m_reg_we, m_status_rd;

  task automatic model_reset();
    mq.delete();
    m_addr = 0; m_code = 0; m_rdbuf = 0; m_fd = 0; m_ovf = 0;
    m_reg_we = 0; m_reg_idx = 0; m_reg_data = 0; m_status_rd = 0;
  endtask

  task automatic model_cycle(input bit wr, input bit rd, input bit sel,
                             input int wd, input bit ack, input int mrd);
    bit popd, room;
    entry_t e;
    popd = ack && (mq.size() != 0);
    room = (mq.size() < QD) || popd;
    m_reg_we = 0;
    m_status_rd = 0;
    if (popd) begin
      e = mq.pop_front();
      if (!e.we) m_rdbuf = mrd;
    end
    if (wr && sel) begin
      if (!m_fd) begin
        m_addr = (m_addr / 256) * 256 + wd;
        m_fd = 1;
      end else begin
        m_fd = 0;
        m_code = wd / 64;
        m_addr = (m_addr % 256) + (wd % (1 << (AW - 8))) * 256;
        if (m_code == 0 && room) begin
          e.we = 0; e.tgt = 0; e.addr = m_addr; e.data = 0;
          mq.push_back(e);
          m_addr = (m_addr + 1) % ASIZE;
        end
        if (m_code == 2) begin
          m_reg_we = 1;
          m_reg_idx = wd % 16;
          m_reg_data = m_addr % 256;
        end
      end
    end else if (wr) begin
      m_fd = 0;
      if (room) begin
        e.we = 1; e.tgt = (m_code == 3); e.addr = m_addr; e.data = wd;
        mq.push_back(e);
        m_addr = (m_addr + 1) % ASIZE;
      end else m_ovf = 1;
`ifdef VDP_WRBUF_LOAD_EN
      m_rdbuf = wd;
`endif
    end else if (rd && sel) begin
      m_fd = 0; m_ovf = 0; m_status_rd = 1;
    end else if (rd) begin
      m_fd = 0;
      if (room) begin
        e.we = 0; e.tgt = 0; e.addr = m_addr; e.data = 0;
        mq.push_back(e);
        m_addr = (m_addr + 1) % ASIZE;
      end else m_ovf = 1;
    end
  endtask

  // ---------------- sampled DUT outputs and model expectations ----------------
  logic [7:0]    s_rdata, s_wdata, s_reg_data;
  logic [AW-1:0] s_addr;
  logic [3:0]    s_reg_idx;
  logic          s_req, s_we, s_tgt, s_full, s_ovf, s_reg_we, s_status_rd;
  logic [7:0]    e_rdata, e_wdata, e_reg_data;
  logic [AW-1:0] e_addr;
  logic [3:0]    e_reg_idx;
  logic          e_req, e_we, e_tgt, e_full, e_ovf, e_reg_we, e_status_rd;

  // One clock of stimulus: drive on the falling edge, sample 1 ns later
  // (state from the previous rising edge), then advance the model.
  task automatic step(input bit wr, input bit rd, input bit sel,
                      input logic [7:0] wd, input bit ack, input logic [7:0] mrd);
    @(negedge clk);
    cs_wr = wr; cs_rd = rd; sel_ctrl = sel; wdata = wd;
    mem_ack = ack; mem_rdata = mrd; status_in = 8'($urandom);
    #1;
    s_rdata = rdata; s_req = mem_req; s_we = mem_we; s_tgt = mem_tgt;
    s_addr = mem_addr; s_wdata = mem_wdata; s_full = q_full; s_ovf = ovf;
    s_reg_we = reg_we; s_reg_idx = reg_idx; s_reg_data = reg_data;
    s_status_rd = status_rd;
    e_rdata = sel ? status_in : 8'(m_rdbuf);
    e_req = (mq.size() != 0);
    e_full = (mq.size() == QD);
    e_we = 0; e_tgt = 0; e_addr = '0; e_wdata = 8'h00;
    if (e_req) begin
      e_we = mq[0].we; e_tgt = mq[0].tgt;
      e_addr = AW'(mq[0].addr); e_wdata = 8'(mq[0].data);
    end
    e_ovf = m_ovf; e_reg_we = m_reg_we; e_reg_idx = 4'(m_reg_idx);
    e_reg_data = 8'(m_reg_data); e_status_rd = m_status_rd;
    @(posedge clk);
    model_cycle(wr, rd, sel, int'(wd), ack, int'(mrd));
  endtask

  task automatic idle(input bit ack, input logic [7:0] mrd);
    step(0, 0, 0, 8'h00, ack, mrd);
  endtask

  task automatic drain();
    for (int i = 0; i < QD + 1; i++) idle(1, 8'($urandom));
  endtask

  task automatic ctrl_rd();
    step(0, 1, 1, 8'h00, 0, 8'h00);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_L = 0; cs_wr = 0; cs_rd = 0; sel_ctrl = 0; wdata = 0;
    mem_ack = 0; mem_rdata = 0; status_in = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset_L = 1;
    idle(0, 8'h00);
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", s_req); end
    checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", s_full); end
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", s_ovf); end
    checks++; if (s_reg_we !== 1'b0) begin errors++; $display("FAIL reset_reg_we got %b want 0", s_reg_we); end
    checks++; if (s_status_rd !== 1'b0) begin errors++; $display("FAIL reset_status_rd got %b want 0", s_status_rd); end
    checks++; if (s_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdbuf got %h want 00", s_rdata); end
    $display("test_reset: done");
  endtask

  task automatic test_vram_write();
    ctrl_rd();
    step(1, 0, 1, 8'h00, 0, 8'h00);
    step(1, 0, 1, 8'h40, 0, 8'h00);
    step(1, 0, 0, 8'hAA, 1, 8'h00);
    step(1, 0, 0, 8'hBB, 1, 8'h00);
    checks++; if ({s_req, s_we, s_tgt, s_addr, s_wdata} !== {1'b1, 1'b1, 1'b0, 14'h0000, 8'hAA})
      begin errors++; $display("FAIL vram_wr0 got req=%b we=%b tgt=%b a=%h d=%h want 1 1 0 0000 aa", s_req, s_we, s_tgt, s_addr, s_wdata); end
    idle(1, 8'h00);
    checks++; if ({s_req, s_we, s_tgt, s_addr, s_wdata} !== {1'b1, 1'b1, 1'b0, 14'h0001, 8'hBB})
      begin errors++; $display("FAIL vram_wr1 got req=%b we=%b tgt=%b a=%h d=%h want 1 1 0 0001 bb", s_req, s_we, s_tgt, s_addr, s_wdata); end
    step(1, 0, 0, 8'hCC, 0, 8'h00);
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL vram_empty got %b want 0", s_req); end
    idle(0, 8'h00);
    checks++; if (s_addr !== 14'h0002) begin errors++; $display("FAIL vram_addr2 got %h want 0002", s_addr); end
    drain();
    $display("test_vram_write: done");
  endtask

  task automatic test_prefetch();
    ctrl_rd();
    step(1, 0, 1, 8'h34, 0, 8'h00);
    step(1, 0, 1, 8'h00, 0, 8'h00);
    idle(1, 8'h5C);
    checks++; if ({s_req, s_we, s_addr} !== {1'b1, 1'b0, 14'h0034})
      begin errors++; $display("FAIL pf_head got req=%b we=%b a=%h want 1 0 0034", s_req, s_we, s_addr); end
    step(0, 1, 0, 8'h00, 0, 8'h00);
    checks++; if (s_rdata !== 8'h5C) begin errors++; $display("FAIL pf_rdata got %h want 5c", s_rdata); end
    idle(0, 8'h00);
    checks++; if ({s_req, s_we, s_addr} !== {1'b1, 1'b0, 14'h0035})
      begin errors++; $display("FAIL pf_next got req=%b we=%b a=%h want 1 0 0035", s_req, s_we, s_addr); end
    drain();
    $display("test_prefetch: done");
  endtask

  task automatic test_reg_write();
    ctrl_rd();
    step(1, 0, 1, 8'h07, 0, 8'h00);
    step(1, 0, 1, 8'h81, 0, 8'h00);
    idle(0, 8'h00);
    checks++; if ({s_reg_we, s_reg_idx, s_reg_data} !== {1'b1, 4'h1, 8'h07})
      begin errors++; $display("FAIL reg_pulse got we=%b idx=%h d=%h want 1 1 07", s_reg_we, s_reg_idx, s_reg_data); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reg_noreq got %b want 0", s_req); end
    idle(0, 8'h00);
    checks++; if (s_reg_we !== 1'b0) begin errors++; $display("FAIL reg_oneshot got %b want 0", s_reg_we); end
    $display("test_reg_write: done");
  endtask

  task automatic test_wrap_cram();
    ctrl_rd();
    step(1, 0, 1, 8'hFF, 0, 8'h00);
    step(1, 0, 1, 8'h7F, 0, 8'h00);
    step(1, 0, 0, 8'h11, 0, 8'h00);
    idle(0, 8'h00);
    checks++; if ({s_req, s_we, s_tgt, s_addr, s_wdata} !== {1'b1, 1'b1, 1'b0, 14'h3FFF, 8'h11})
      begin errors++; $display("FAIL wrap_top got req=%b we=%b tgt=%b a=%h d=%h want 1 1 0 3fff 11", s_req, s_we, s_tgt, s_addr, s_wdata); end
    idle(1, 8'h00);
    step(1, 0, 0, 8'h22, 0, 8'h00);
    idle(0, 8'h00);
    checks++; if (s_addr !== 14'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", s_addr); end
    idle(1, 8'h00);
    step(1, 0, 1, 8'h03, 0, 8'h00);
    step(1, 0, 1, 8'hC0, 0, 8'h00);
    step(1, 0, 0, 8'h3F, 0, 8'h00);
    idle(0, 8'h00);
    checks++; if ({s_req, s_we, s_tgt, s_addr[4:0], s_wdata} !== {1'b1, 1'b1, 1'b1, 5'd3, 8'h3F})
      begin errors++; $display("FAIL cram_wr got req=%b we=%b tgt=%b a=%h d=%h want 1 1 1 03 3f", s_req, s_we, s_tgt, s_addr[4:0], s_wdata); end
    drain();
    $display("test_wrap_cram: done");
  endtask

  task automatic test_overflow();
    ctrl_rd();
    step(1, 0, 1, 8'h00, 0, 8'h00);
    step(1, 0, 1, 8'h40, 0, 8'h00);
    for (int i = 0; i < QD + 1; i++) step(1, 0, 0, 8'(8'h50 + i), 0, 8'h00);
    checks++; if (s_full !== 1'b1) begin errors++; $display("FAIL ovf_full_before got %b want 1", s_full); end
    idle(0, 8'h00);
    checks++; if ({s_full, s_ovf} !== 2'b11) begin errors++; $display("FAIL ovf_set got full=%b ovf=%b want 1 1", s_full, s_ovf); end
    for (int i = 0; i < QD; i++) begin
      idle(1, 8'h00);
      checks++; if ({s_addr, s_wdata} !== {14'(i), 8'(8'h50 + i)})
        begin errors++; $display("FAIL ovf_drain%0d got a=%h d=%h want %h %h", i, s_addr, s_wdata, 14'(i), 8'(8'h50 + i)); end
    end
    step(1, 0, 0, 8'h99, 0, 8'h00);
    idle(0, 8'h00);
    checks++; if (s_addr !== 14'(QD)) begin errors++; $display("FAIL ovf_addr got %h want %h", s_addr, 14'(QD)); end
    idle(1, 8'h00);
    ctrl_rd();
    checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", s_ovf); end
    idle(0, 8'h00);
    checks++; if ({s_status_rd, s_ovf} !== 2'b10)
      begin errors++; $display("FAIL ovf_clear got status_rd=%b ovf=%b want 1 0", s_status_rd, s_ovf); end
    $display("test_overflow: done");
  endtask

  task automatic test_first_done();
    ctrl_rd();
    step(1, 0, 1, 8'h12, 0, 8'h00);
    step(0, 1, 0, 8'h00, 0, 8'h00);
    drain();
    step(1, 0, 1, 8'h56, 0, 8'h00);
    step(1, 0, 1, 8'h41, 0, 8'h00);
    step(1, 0, 0, 8'h77, 0, 8'h00);
    idle(0, 8'h00);
    checks++; if ({s_req, s_we, s_addr, s_wdata} !== {1'b1, 1'b1, 14'h0156, 8'h77})
      begin errors++; $display("FAIL fd_clear got req=%b we=%b a=%h d=%h want 1 1 0156 77", s_req, s_we, s_addr, s_wdata); end
    drain();
    $display("test_first_done: done");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      bit ack_bias = ((i / 60) % 2) == 0;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
           8'($urandom), ack_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0),
           8'($urandom));
      checks++;
      if (s_req !== e_req || s_full !== e_full || s_ovf !== e_ovf || s_rdata !== e_rdata ||
          s_reg_we !== e_reg_we || s_status_rd !== e_status_rd ||
          (e_reg_we && {s_reg_idx, s_reg_data} !== {e_reg_idx, e_reg_data}) ||
          (e_req && (s_we !== e_we || s_tgt !== e_tgt ||
                     (e_tgt ? (s_addr[4:0] !== e_addr[4:0]) : (s_addr !== e_addr)) ||
                     (e_we && s_wdata !== e_wdata)))) begin
        errors++; bad++;
        if (bad <= 10)
          $display("FAIL rand%0d got req=%b full=%b ovf=%b rd=%h rwe=%b st=%b we=%b tgt=%b a=%h d=%h want %b %b %b %h %b %b %b %b %h %h",
                   i, s_req, s_full, s_ovf, s_rdata, s_reg_we, s_status_rd, s_we, s_tgt, s_addr, s_wdata,
                   e_req, e_full, e_ovf, e_rdata, e_reg_we, e_status_rd, e_we, e_tgt, e_addr, e_wdata);
      end
    end
    drain();
    $display("test_random: done, %0d cycle mismatches", bad);
  endtask

  task automatic test_reset_mid();
    ctrl_rd();
    for (int i = 0; i < QD; i++) step(1, 0, 0, 8'(i), 0, 8'h00);
    idle(0, 8'h00);
    checks++; if ({s_req, s_full} !== 2'b11) begin errors++; $display("FAIL rstmid_pre got req=%b full=%b want 1 1", s_req, s_full); end
    @(negedge clk);
    #2 reset_L = 0;
    #1;
    checks++; if ({mem_req, q_full} !== 2'b00)
      begin errors++; $display("FAIL rstmid_async got req=%b full=%b want 0 0", mem_req, q_full); end
    model_reset();
    @(negedge clk); reset_L = 1;
    idle(0, 8'h00);
    checks++; if ({s_req, s_full, s_rdata} !== {1'b0, 1'b0, 8'h00})
      begin errors++; $display("FAIL rstmid_after got req=%b full=%b rd=%h want 0 0 00", s_req, s_full, s_rdata); end
    $display("test_reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_vram_write();
    test_prefetch();
    test_reg_write();
    test_wrap_cram();
    test_overflow();
    test_first_done();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
